// File: rtl/ann_frame_pkg.sv
// Shared types for the ANN input-frame loader: capture modes, FSM states and sample type.
package ann_frame_pkg;
  localparam int DATA_W = 10;

  typedef logic [DATA_W-1:0] sample_t;

  typedef enum logic [1:0] {
    MODE_STREAM  = 2'd0,
    MODE_PATTERN = 2'd1,
    MODE_ZERO    = 2'd2,
    MODE_HOLD    = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_READY = 2'd2,
    ST_ABORT = 2'd3
  } state_e;
endpackage

// File: rtl/frame_tick_timer.sv
// Counts 1 s strobes while a stream fill is in progress and flags when the fill budget runs out.
module frame_tick_timer #(
  parameter int TIMEOUT_TICKS = 5,
  localparam int TW = $clog2(TIMEOUT_TICKS + 1)
) (
  input  logic clk,
  input  logic srst,
  input  logic clear,
  input  logic enable,
  input  logic tick,
  output logic expired
);
  localparam logic [TW-1:0] LIMIT = TW'(TIMEOUT_TICKS);

  logic [TW-1:0] tick_reg;

  always_ff @(posedge clk) begin
    if (srst || clear) begin
      tick_reg <= '0;
    end else if (enable && tick && tick_reg != LIMIT) begin
      tick_reg <= tick_reg + 1'b1;
    end
  end

  // Also true in the cycle the final strobe arrives, so the FSM can arbitrate it against a last sample.
  assign expired = (tick_reg == LIMIT) || (enable && tick && tick_reg == LIMIT - 1'b1);
endmodule

// File: rtl/ann_frame_loader.sv
// Captures an ANN input frame from stream/pattern/zero/hold sources and presents it with targets.
module ann_frame_loader #(
  parameter int N_IN          = 30,
  parameter int DATA_W        = 10,
  parameter int N_OUT         = 3,
  parameter int PATTERN_VAL   = 200,
  parameter int TARGET_HI     = 1000,
  parameter int TIMEOUT_TICKS = 5,
  localparam int CNT_W = $clog2(N_IN + 1)
) (
  input  logic              Clock,
  input  logic              Rst,
  input  logic              Start,
  input  logic [1:0]        mode,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  input  logic              clock1sec,
  input  logic [N_OUT-1:0]  target_sel,
  output logic [DATA_W-1:0] frame_out [0:N_IN-1],
  output logic [DATA_W-1:0] target_out [N_OUT-1:0],
  output logic              frame_valid,
  input  logic              frame_ack,
  output logic [CNT_W-1:0]  count,
  output logic              timeout,
  output logic [1:0]        state
);
  import ann_frame_pkg::*;

  state_e            state_reg;
  logic [N_OUT-1:0]  tsel_q;
  logic [CNT_W-1:0]  count_reg;
  logic              s_ready_reg;
  logic              frame_valid_reg;
  logic              timeout_reg;
  logic              commit_reg;
  logic [DATA_W-1:0] shadow [0:N_IN-1];
  logic [DATA_W-1:0] frame_reg [0:N_IN-1];
  logic [DATA_W-1:0] target_reg [N_OUT-1:0];

  logic start_ok;
  logic accept;
  logic last;
  logic expired;

  assign start_ok = Start && (state_reg == ST_IDLE);
  assign accept   = s_valid && s_ready_reg;
  assign last     = accept && (count_reg == CNT_W'(N_IN - 1));

  frame_tick_timer #(.TIMEOUT_TICKS(TIMEOUT_TICKS)) u_timer (
    .clk     (Clock),
    .srst    (Rst),
    .clear   (start_ok),
    .enable  (state_reg == ST_FILL),
    .tick    (clock1sec),
    .expired (expired)
  );

  always_ff @(posedge Clock) begin
    if (Rst) begin
      state_reg       <= ST_IDLE;
      tsel_q          <= '0;
      count_reg       <= '0;
      s_ready_reg     <= 1'b0;
      frame_valid_reg <= 1'b0;
      timeout_reg     <= 1'b0;
      commit_reg      <= 1'b0;
      for (int i = 0; i < N_IN; i++) shadow[i] <= '0;
    end else begin
      timeout_reg <= 1'b0;
      commit_reg  <= 1'b0;
      if (commit_reg) frame_valid_reg <= 1'b1;
      case (state_reg)
        ST_IDLE: begin
          if (Start) begin
            tsel_q    <= target_sel;
            count_reg <= '0;
            case (mode_e'(mode))
              MODE_STREAM: begin
                state_reg   <= ST_FILL;
                s_ready_reg <= 1'b1;
              end
              MODE_PATTERN: begin
                for (int i = 0; i < N_IN; i++) shadow[i] <= DATA_W'(PATTERN_VAL);
                state_reg  <= ST_READY;
                commit_reg <= 1'b1;
              end
              MODE_ZERO: begin
                for (int i = 0; i < N_IN; i++) shadow[i] <= '0;
                state_reg  <= ST_READY;
                commit_reg <= 1'b1;
              end
              default: begin
                state_reg  <= ST_READY;
                commit_reg <= 1'b1;
              end
            endcase
          end
        end
        ST_FILL: begin
          if (accept) begin
            shadow[count_reg] <= s_data;
            count_reg         <= count_reg + 1'b1;
          end
          // A completing sample beats a timeout landing in the same cycle.
          if (last) begin
            state_reg   <= ST_READY;
            s_ready_reg <= 1'b0;
            commit_reg  <= 1'b1;
          end else if (expired) begin
            state_reg   <= ST_ABORT;
            s_ready_reg <= 1'b0;
            timeout_reg <= 1'b1;
          end
        end
        ST_READY: begin
          if (frame_valid_reg && frame_ack) begin
            state_reg       <= ST_IDLE;
            frame_valid_reg <= 1'b0;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  for (genvar gi = 0; gi < N_IN; gi++) begin : g_frame
    always_ff @(posedge Clock) begin
      if (Rst) frame_reg[gi] <= '0;
      else if (commit_reg) frame_reg[gi] <= shadow[gi];
    end
    assign frame_out[gi] = frame_reg[gi];
  end

  for (genvar gi = 0; gi < N_OUT; gi++) begin : g_target
    always_ff @(posedge Clock) begin
      if (Rst) target_reg[gi] <= '0;
      else if (commit_reg) target_reg[gi] <= tsel_q[gi] ? DATA_W'(TARGET_HI) : '0;
    end
    assign target_out[gi] = target_reg[gi];
  end

  assign s_ready     = s_ready_reg;
  assign frame_valid = frame_valid_reg;
  assign count       = count_reg;
  assign timeout     = timeout_reg;
  assign state       = state_reg;
endmodule

// File: tb/tb_ann_frame_loader.sv
// Directed bench for ann_frame_loader: each capture mode, timeout abort, handshake and reset behaviour.
module tb_ann_frame_loader;
  localparam int N_IN = 30;
  localparam int DW   = 10;
  localparam int N_OUT = 3;

  logic          Clock = 1'b0;
  logic          Rst, Start, s_valid, clock1sec, frame_ack;
  logic [1:0]    mode;
  logic [DW-1:0] s_data;
  logic [N_OUT-1:0] target_sel;
  logic          s_ready, frame_valid, timeout;
  logic [DW-1:0] frame_out [0:N_IN-1];
  logic [DW-1:0] target_out [N_OUT-1:0];
  logic [4:0]    count;
  logic [1:0]    state;

  int checks = 0;
  int errors = 0;

  ann_frame_loader dut (
    .Clock(Clock), .Rst(Rst), .Start(Start), .mode(mode),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .clock1sec(clock1sec), .target_sel(target_sel),
    .frame_out(frame_out), .target_out(target_out),
    .frame_valid(frame_valid), .frame_ack(frame_ack),
    .count(count), .timeout(timeout), .state(state)
  );

  always #5 Clock = ~Clock;

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic chk_frame(input string tag, input int base, input int inc);
    for (int i = 0; i < N_IN; i++)
      chk($sformatf("%s[%0d]", tag, i), 32'(frame_out[i]), 32'(base + i * inc));
  endtask

  task automatic start_cmd(input logic [1:0] m, input logic [N_OUT-1:0] ts);
    Start = 1'b1; mode = m; target_sel = ts;
    step();
    Start = 1'b0;
  endtask

  task automatic ack();
    frame_ack = 1'b1;
    step();
    frame_ack = 1'b0;
  endtask

  task automatic send(input int v, input logic tk);
    s_valid = 1'b1; s_data = DW'(v); clock1sec = tk;
    step();
    s_valid = 1'b0; clock1sec = 1'b0;
  endtask

  initial begin
    Rst = 1'b1; Start = 1'b0; mode = 2'd0; s_valid = 1'b0; s_data = '0;
    clock1sec = 1'b0; target_sel = '0; frame_ack = 1'b0;
    step(); step();
    Rst = 1'b0;
    chk("rst_state", 32'(state), 0);
    chk("rst_valid", 32'(frame_valid), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_s_ready", 32'(s_ready), 0);
    chk("rst_timeout", 32'(timeout), 0);
    chk("rst_frame0", 32'(frame_out[0]), 0);
    chk("rst_target2", 32'(target_out[2]), 0);
    $display("txn reset done");

    // 1: PATTERN, valid two cycles after Start
    start_cmd(2'd1, 3'b101);
    chk("t1_valid_c1", 32'(frame_valid), 0);
    chk("t1_state_c1", 32'(state), 2);
    step();
    chk("t1_valid_c2", 32'(frame_valid), 1);
    chk_frame("t1_frame", 200, 0);
    chk("t1_tgt2", 32'(target_out[2]), 1000);
    chk("t1_tgt1", 32'(target_out[1]), 0);
    chk("t1_tgt0", 32'(target_out[0]), 1000);
    ack();
    chk("t1_ack_valid", 32'(frame_valid), 0);
    chk("t1_ack_state", 32'(state), 0);
    $display("txn pattern frame + ack");

    // 2: STREAM 0..29 with gaps
    start_cmd(2'd0, 3'b010);
    chk("t2_state", 32'(state), 1);
    chk("t2_s_ready", 32'(s_ready), 1);
    chk("t2_count0", 32'(count), 0);
    for (int i = 0; i < N_IN; i++) begin
      if (i % 4 == 3) step();
      send(i, 1'b0);
    end
    chk("t2_count", 32'(count), 30);
    chk("t2_state_rdy", 32'(state), 2);
    chk("t2_valid_early", 32'(frame_valid), 0);
    step();
    chk("t2_valid", 32'(frame_valid), 1);
    chk_frame("t2_frame", 0, 1);
    chk("t2_tgt1", 32'(target_out[1]), 1000);
    chk("t2_tgt0", 32'(target_out[0]), 0);
    $display("txn stream frame 0..29");

    // 4: Start and samples ignored in READY, then ack
    Start = 1'b1; mode = 2'd1; s_valid = 1'b1; s_data = 10'd7;
    step();
    Start = 1'b0; s_valid = 1'b0;
    chk("t4_s_ready", 32'(s_ready), 0);
    chk("t4_state", 32'(state), 2);
    chk("t4_count", 32'(count), 30);
    step();
    chk("t4_frame0", 32'(frame_out[0]), 0);
    chk("t4_frame1", 32'(frame_out[1]), 1);
    ack();
    chk("t4_ack_valid", 32'(frame_valid), 0);
    $display("txn ready ignores start/samples, ack");

    // 3: partial stream then timeout
    start_cmd(2'd0, 3'b000);
    for (int i = 0; i < 12; i++) send(500 + i, 1'b0);
    chk("t3_count", 32'(count), 12);
    for (int k = 0; k < 4; k++) begin
      clock1sec = 1'b1; step(); clock1sec = 1'b0; step();
    end
    chk("t3_state_pre", 32'(state), 1);
    chk("t3_timeout_pre", 32'(timeout), 0);
    clock1sec = 1'b1; step(); clock1sec = 1'b0;
    chk("t3_timeout", 32'(timeout), 1);
    chk("t3_state_abort", 32'(state), 3);
    chk("t3_s_ready", 32'(s_ready), 0);
    step();
    chk("t3_timeout_off", 32'(timeout), 0);
    chk("t3_state_idle", 32'(state), 0);
    chk("t3_frame0", 32'(frame_out[0]), 0);
    chk("t3_frame29", 32'(frame_out[29]), 29);
    chk("t3_valid", 32'(frame_valid), 0);
    $display("txn stream timeout abort");

    // 7: last sample coincides with final tick -> sample wins
    start_cmd(2'd0, 3'b000);
    for (int i = 0; i < N_IN - 1; i++) send(i, i < 4);
    send(99, 1'b1);
    chk("t7_state", 32'(state), 2);
    chk("t7_timeout", 32'(timeout), 0);
    step();
    chk("t7_valid", 32'(frame_valid), 1);
    chk("t7_frame29", 32'(frame_out[29]), 99);
    ack();
    $display("txn last sample beats final tick");

    // 5: PATTERN, ZERO, HOLD
    start_cmd(2'd1, 3'b001);
    step();
    chk("t5_pat5", 32'(frame_out[5]), 200);
    ack();
    start_cmd(2'd2, 3'b111);
    step();
    chk("t5_zero_valid", 32'(frame_valid), 1);
    chk_frame("t5_zero", 0, 0);
    chk("t5_zero_tgt2", 32'(target_out[2]), 1000);
    chk("t5_zero_tgt0", 32'(target_out[0]), 1000);
    ack();
    start_cmd(2'd3, 3'b010);
    step();
    chk("t5_hold_valid", 32'(frame_valid), 1);
    chk_frame("t5_hold", 0, 0);
    chk("t5_hold_tgt1", 32'(target_out[1]), 1000);
    chk("t5_hold_tgt2", 32'(target_out[2]), 0);
    ack();
    $display("txn pattern/zero/hold sequence");

    // 6: reset mid-fill discards partial frame
    start_cmd(2'd1, 3'b111);
    step();
    ack();
    start_cmd(2'd0, 3'b000);
    for (int i = 0; i < 17; i++) send(300 + i, 1'b0);
    chk("t6_count", 32'(count), 17);
    Rst = 1'b1;
    step();
    Rst = 1'b0;
    chk("t6_state", 32'(state), 0);
    chk("t6_count_rst", 32'(count), 0);
    chk("t6_s_ready", 32'(s_ready), 0);
    chk("t6_valid", 32'(frame_valid), 0);
    chk("t6_frame3", 32'(frame_out[3]), 0);
    chk("t6_tgt0", 32'(target_out[0]), 0);
    start_cmd(2'd3, 3'b100);
    step();
    chk("t6_hold_valid", 32'(frame_valid), 1);
    chk_frame("t6_hold", 0, 0);
    chk("t6_hold_tgt2", 32'(target_out[2]), 1000);
    $display("txn reset mid-fill then hold");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
